ternary_route_demux: RTL

// - Inverse of the team's 3-bit-select nested-ternary 5-source mux: steers one input stream to one of

---
 rtl/ternary_route_pkg.sv | 30 +++
 rtl/lane_fifo2.sv | 60 ++++++
 rtl/ternary_route_demux.sv | 54 +++++
 3 files changed

// File: rtl/ternary_route_pkg.sv
// Shared lane enumeration and select-code decode for the ternary mux/router pair.
package ternary_route_pkg;

  localparam int NUM_LANES = 5;

  typedef enum logic [2:0] {
    LANE_A = 3'd0,
    LANE_B = 3'd1,
    LANE_C = 3'd2,
    LANE_D = 3'd3,
    LANE_E = 3'd4
  } lane_e;

  // Same code table as the 5-source nested-ternary mux, so both ends agree on codes.
  function automatic lane_e sel_to_lane(input logic [2:0] sel);
    lane_e lane;
    case (sel)
      3'b111:  lane = LANE_A;
      3'b110:  lane = LANE_B;
      3'b101:  lane = LANE_C;
      3'b100:  lane = LANE_D;
      3'b011:  lane = LANE_E;
      3'b010:  lane = LANE_A;
      3'b001:  lane = LANE_B;
      default: lane = LANE_C;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/lane_fifo2.sv
// Two-entry per-lane FIFO with a registered head word that holds its last value when empty.
module lane_fifo2 #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic         not_full
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_next;
  logic [W-1:0] head_next;
  logic         push_ok;
  logic         pop_ok;

  assign not_full   = int'(count) < DEPTH;
  assign head_valid = (count != 2'd0);
  assign push_ok    = push && not_full;
  assign pop_ok     = pop && head_valid;

  // The head is kept as its own register so an emptied lane keeps showing its last word.
  always_comb begin
    count_next = count + {1'b0, push_ok} - {1'b0, pop_ok};
    head_next  = head_data;
    if (count_next != 2'd0) begin
      if ((count == 2'd0) || (pop_ok && (count == 2'd1)))
        head_next = push_data;
      else if (pop_ok)
        head_next = mem[~rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      head_data <= '0;
    end else begin
      if (push_ok)
        mem[wr_ptr] <= push_data;
      wr_ptr    <= wr_ptr ^ push_ok;
      rd_ptr    <= rd_ptr ^ pop_ok;
      count     <= count_next;
      head_data <= head_next;
    end
  end

endmodule

// File: rtl/ternary_route_demux.sv
// Steers one valid/ready input stream to one of five lane FIFOs using the shared select-code table.
module ternary_route_demux
  import ternary_route_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_sel,
  input  logic [W-1:0]           in_data,
  output logic [NUM_LANES-1:0]   out_valid,
  input  logic [NUM_LANES-1:0]   out_ready,
  output logic [NUM_LANES*W-1:0] out_data,
  output logic                   busy
);

  lane_e                target;
  logic [NUM_LANES-1:0] lane_hit;
  logic [NUM_LANES-1:0] lane_push;
  logic [NUM_LANES-1:0] not_full;

  assign target = sel_to_lane(in_sel);

  // Ready only looks at the addressed lane's occupancy, so it never depends on valid or out_ready.
  always_comb begin
    lane_hit = '0;
    for (int k = 0; k < NUM_LANES; k++)
      lane_hit[k] = (int'(target) == k);
  end

  assign in_ready  = |(lane_hit & not_full);
  assign lane_push = lane_hit & {NUM_LANES{in_valid & in_ready}};
  assign busy      = |out_valid;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_fifo2 #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (lane_push[k]),
      .push_data  (in_data),
      .pop        (out_ready[k]),
      .head_valid (out_valid[k]),
      .head_data  (out_data[k*W +: W]),
      .not_full   (not_full[k])
    );
  end

endmodule
